// File: rtl/oam_dma_pkg.sv
// Shared PPU-side definitions: sprite DMA state encoding, the $4014 trigger
// register address and the nametable mirroring selector.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } dma_state_t;

  typedef enum logic [1:0] {
    MIR_HORZ,
    MIR_VERT,
    MIR_SCR0,
    MIR_SCR1
  } mirror_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a $4014 write, stall the CPU and copy one CPU page into OAM
// as read/write pairs, stepping only on the CPU clock enable.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int OAM_W    = 8,
  parameter bit ALIGN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             dma_req,
  input  logic [7:0]       dma_page,
  input  logic [OAM_W-1:0] oam_base,
  output logic             cpu_stall,
  output logic             mem_re,
  output logic [15:0]      mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic             oam_we,
  output logic [OAM_W-1:0] oam_addr,
  output logic [7:0]       oam_wdata,
  output logic             dma_done,
  output logic             busy
);

  dma_state_t       state_q, state_d;
  logic [OAM_W-1:0] idx_q, idx_d;
  logic [OAM_W-1:0] base_q, base_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      page_q   <= '0;
      wdata_q  <= '0;
      parity_q <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      page_q   <= page_d;
      wdata_q  <= wdata_d;
      parity_q <= ~parity_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    page_d  = page_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (dma_req) begin
          page_d  = dma_page;
          base_d  = oam_base;
          idx_d   = '0;
          state_d = S_HALT;
        end
      end
      // parity 0 here means the following cycle is a put, so burn one more
      S_HALT:  state_d = (ALIGN_EN && !parity_q) ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        wdata_d = mem_rdata;
        if (&idx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_stall = (state_q == S_HALT) || (state_q == S_ALIGN) ||
                     (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_re    = clk_en && (state_q == S_READ);
  assign mem_addr  = {page_q, 8'h00} + 16'(idx_q);
  assign oam_we    = clk_en && (state_q == S_WRITE);
  assign oam_addr  = base_q + idx_q;
  // read data is live during WRITE; the latched copy holds it afterwards
  assign oam_wdata = (state_q == S_WRITE) ? mem_rdata : wdata_q;
  assign dma_done  = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: transfer table, wrap spot checks, retrigger,
// mid-transfer reset and clock-enable gating, with ALIGN_EN=1 and 0 instances.
module tb_oam_dma;

  typedef struct {
    logic [7:0] page;
    logic [7:0] base;
    bit         par;
    int         div;
    int         st0;
    int         st1;
    int         retrig;
  } xfer_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] e;
  } spot_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       dma_req = 1'b0;
  logic [7:0] dma_page = 8'h00;
  logic [7:0] oam_base = 8'h00;

  logic        cpu_stall0, mem_re0, oam_we0, done0, busy0;
  logic [15:0] mem_addr0;
  logic [7:0]  oam_addr0, oam_wdata0;
  logic [7:0]  rdata0 = 8'h00;
  logic        cpu_stall1, mem_re1, oam_we1, done1, busy1;
  logic [15:0] mem_addr1;
  logic [7:0]  oam_addr1, oam_wdata1;
  logic [7:0]  rdata1 = 8'h00;

  logic [7:0] ram  [0:65535];
  logic [7:0] oam0 [0:255];
  logic [7:0] oam1 [0:255];
  logic [7:0] prev [0:255];

  int stall0 = 0, stall1 = 0, dcnt0 = 0, dcnt1 = 0, wcnt0 = 0, viol = 0;
  bit ptrack = 1'b0;
  int cyc = 0, div = 1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  oam_dma #(.OAM_W(8), .ALIGN_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .dma_req(dma_req),
    .dma_page(dma_page), .oam_base(oam_base), .cpu_stall(cpu_stall0),
    .mem_re(mem_re0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
    .oam_we(oam_we0), .oam_addr(oam_addr0), .oam_wdata(oam_wdata0),
    .dma_done(done0), .busy(busy0)
  );

  oam_dma #(.OAM_W(8), .ALIGN_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .dma_req(dma_req),
    .dma_page(dma_page), .oam_base(oam_base), .cpu_stall(cpu_stall1),
    .mem_re(mem_re1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
    .oam_we(oam_we1), .oam_addr(oam_addr1), .oam_wdata(oam_wdata1),
    .dma_done(done1), .busy(busy1)
  );

  // CPU bus RAM with one-step read latency, OAM arrays and event counters
  always @(posedge clk) begin
    if (clk_en && mem_re0) rdata0 <= ram[mem_addr0];
    if (clk_en && mem_re1) rdata1 <= ram[mem_addr1];
    if (oam_we0) begin
      oam0[oam_addr0] <= oam_wdata0;
      wcnt0 <= wcnt0 + 1;
    end
    if (oam_we1) oam1[oam_addr1] <= oam_wdata1;
    if (clk_en && cpu_stall0) stall0 <= stall0 + 1;
    if (clk_en && cpu_stall1) stall1 <= stall1 + 1;
    if (clk_en && done0) dcnt0 <= dcnt0 + 1;
    if (clk_en && done1) dcnt1 <= dcnt1 + 1;
    if (!clk_en && (oam_we0 || mem_re0 || oam_we1 || mem_re1)) viol <= viol + 1;
    if (!rst_n) ptrack <= 1'b0;
    else if (clk_en) ptrack <= ~ptrack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    clk_en = ((cyc % div) == 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input xfer_t v);
    int s0, s1, d0, d1, w0, guard, m0, m1;
    bit rt;
    div = v.div;
    guard = 0;
    while (!(clk_en && (ptrack == v.par) && !busy0 && !busy1) && guard < 100) begin
      tick();
      guard++;
    end
    chk("start_wait", guard < 100, 1);
    s0 = stall0; s1 = stall1; d0 = dcnt0; d1 = dcnt1; w0 = wcnt0; rt = 1'b0;
    dma_req = 1'b1; dma_page = v.page; oam_base = v.base;
    tick();
    dma_req = 1'b0; dma_page = 8'h5A; oam_base = 8'h33;
    guard = 0;
    while ((busy0 || busy1) && guard < 5000) begin
      if (v.retrig >= 0 && !rt && (wcnt0 - w0) >= v.retrig && clk_en) begin
        dma_req = 1'b1; dma_page = 8'h07; oam_base = 8'h80; rt = 1'b1;
        tick();
        dma_req = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    chk("xfer_timeout", guard < 5000, 1);
    repeat (6) tick();
    chk("stall_len_align", stall0 - s0, v.st0);
    chk("stall_len_noalign", stall1 - s1, v.st1);
    chk("done_pulses0", dcnt0 - d0, 1);
    chk("done_pulses1", dcnt1 - d1, 1);
    m0 = 0; m1 = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] ra;
      logic [7:0]  oa;
      ra = {v.page, 8'(i)};
      oa = v.base + 8'(i);
      if (oam0[oa] !== ram[ra]) m0++;
      if (oam1[oa] !== ram[ra]) m1++;
    end
    chk("oam_data0", m0, 0);
    chk("oam_data1", m1, 0);
  endtask

  initial begin
    xfer_t tv[5];
    spot_t sp[4];
    int guard, w0, d0, m0;

    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      ram[a] = (av[7:0] ^ 8'hA5) + av[15:8];
    end
    for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'(i);

    // page, base, start parity, clk_en divider, stall(align), stall(no align), retrigger write
    tv[0] = '{8'h02, 8'h00, 1'b1, 1, 514, 513, -1};
    tv[1] = '{8'h02, 8'h00, 1'b0, 1, 513, 513, -1};
    tv[2] = '{8'h02, 8'h00, 1'b1, 1, 514, 513, 100};
    tv[3] = '{8'h02, 8'h10, 1'b1, 3, 514, 513, -1};
    tv[4] = '{8'h03, 8'hF0, 1'b0, 1, 513, 513, -1};

    sp[0] = '{8'hF0, 8'h00};
    sp[1] = '{8'hFF, 8'h0F};
    sp[2] = '{8'h00, 8'h10};
    sp[3] = '{8'hEF, 8'hFF};

    repeat (3) tick();
    chk("rst_cpu_stall", cpu_stall0, 0);
    chk("rst_mem_re", mem_re0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_oam_we", oam_we0, 0);
    chk("rst_oam_addr", oam_addr0, 0);
    chk("rst_oam_wdata", oam_wdata0, 0);
    chk("rst_dma_done", done0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    tick();

    foreach (tv[k]) run_xfer(tv[k]);

    foreach (sp[k]) chk($sformatf("wrap_oam_%0h", sp[k].a), oam0[sp[k].a], sp[k].e);

    // reset after 50 writes: OAM keeps the first 50 bytes, the rest untouched
    div = 1;
    for (int i = 0; i < 256; i++) prev[i] = oam0[i];
    guard = 0;
    while (!(clk_en && !busy0 && !busy1) && guard < 100) begin
      tick();
      guard++;
    end
    w0 = wcnt0;
    dma_req = 1'b1; dma_page = 8'h02; oam_base = 8'h00;
    tick();
    dma_req = 1'b0;
    guard = 0;
    while ((wcnt0 - w0) < 50 && guard < 500) begin
      tick();
      guard++;
    end
    chk("mid_rst_reach50", wcnt0 - w0, 50);
    rst_n = 1'b0;
    d0 = dcnt0;
    tick();
    chk("mid_rst_stall", cpu_stall0, 0);
    chk("mid_rst_we", oam_we0, 0);
    chk("mid_rst_re", mem_re0, 0);
    chk("mid_rst_busy", busy0, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_done", dcnt0 - d0, 0);
    chk("mid_rst_idle", busy0, 0);
    m0 = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < 50) begin
        if (oam0[i] !== ram[16'h0200 + i]) m0++;
      end else begin
        if (oam0[i] !== prev[i]) m0++;
      end
    end
    chk("mid_rst_oam", m0, 0);

    chk("clk_en_gating", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
